// File: rtl/fma_special_pipe.sv
// fma_special_pipe: registered special-case and exception-flag stage for x*y+z with sticky flag accumulation.
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   in_valid/in_ready                operand handshake (in_ready = ~out_valid | out_ready)
//   x, y, z, sum                     operands and rounded datapath result
//   nonzero_mant                     rounding lost precision (guard/round/sticky nonzero)
//   nan_prop                         0: canonical NaN, 1: propagate first NaN input quieted
//   out_valid/out_ready              result handshake
//   result, flags, special           final value, {NV,DZ,OF,UF,NX}, special-case indicator
//   fflags_clr, fflags               sticky flag clear and accumulated flags
module fma_special_pipe #(
  parameter int EW = 5,
  parameter int MW = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EW+MW:0]   x,
  input  logic [EW+MW:0]   y,
  input  logic [EW+MW:0]   z,
  input  logic [EW+MW:0]   sum,
  input  logic             nonzero_mant,
  input  logic             nan_prop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW+MW:0]   result,
  output logic [4:0]       flags,
  output logic             special,
  input  logic             fflags_clr,
  output logic [4:0]       fflags
);
  localparam int N = 1 + EW + MW;
  localparam logic [N-1:0] QBIT = {{(EW+1){1'b0}}, 1'b1, {(MW-1){1'b0}}};
  localparam logic [N-1:0] CANON = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
  function automatic logic expOnes(input logic [N-1:0] v);
    return &v[N-2:MW];
  endfunction
  function automatic logic isNan(input logic [N-1:0] v);
    return expOnes(v) & (|v[MW-1:0]);
  endfunction
  function automatic logic isSnan(input logic [N-1:0] v);
    return isNan(v) & ~v[MW-1];
  endfunction
  function automatic logic isInf(input logic [N-1:0] v);
    return expOnes(v) & ~(|v[MW-1:0]);
  endfunction
  function automatic logic isZero(input logic [N-1:0] v);
    return ~(|v[N-2:0]);
  endfunction
  logic ps, xInf, yInf, zInf, xZero, yZero, prodInv, prodInf, anyNan, anySnan;
  logic [N-1:0] propNan, resNext;
  logic [4:0] flNext;
  logic spNext, accept, deliver;
  assign ps = x[N-1] ^ y[N-1];
  assign xInf = isInf(x);
  assign yInf = isInf(y);
  assign zInf = isInf(z);
  assign xZero = isZero(x);
  assign yZero = isZero(y);
  assign prodInv = (xZero & yInf) | (xInf & yZero);
  assign prodInf = xInf | yInf;
  assign anyNan = isNan(x) | isNan(y) | isNan(z);
  assign anySnan = isSnan(x) | isSnan(y) | isSnan(z);
  assign propNan = (isNan(x) ? x : isNan(y) ? y : z) | QBIT;
  assign in_ready = ~out_valid | out_ready;
  assign accept = in_valid & in_ready;
  assign deliver = out_valid & out_ready;
  always_comb begin
    resNext = sum;
    flNext = {3'b000, nonzero_mant & ~(|sum[N-2:MW]), nonzero_mant};
    spNext = 1'b0;
    if (anyNan) begin
      resNext = nan_prop ? propNan : CANON;
      flNext = {anySnan | prodInv, 4'b0000};
      spNext = 1'b1;
    end else if (prodInv | (prodInf & zInf & (z[N-1] != ps))) begin
      resNext = CANON;
      flNext = 5'b10000;
      spNext = 1'b1;
    end else if (prodInf) begin
      resNext = {ps, {EW{1'b1}}, {MW{1'b0}}};
      flNext = 5'b00000;
      spNext = 1'b1;
    end else if (zInf) begin
      resNext = z;
      flNext = 5'b00000;
      spNext = 1'b1;
    end else if (xZero | yZero) begin
      resNext = isZero(z) ? {ps & z[N-1], {(N-1){1'b0}}} : z;
      flNext = 5'b00000;
      spNext = 1'b1;
    end else if (expOnes(sum)) begin
      resNext = {sum[N-1], {EW{1'b1}}, {MW{1'b0}}};
      flNext = 5'b00101;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      result <= '0;
      flags <= '0;
      special <= 1'b0;
      fflags <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        result <= resNext;
        flags <= flNext;
        special <= spNext;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // a delivery in the same cycle as a clear survives the clear
      fflags <= (fflags_clr ? 5'b00000 : fflags) | (deliver ? flags : 5'b00000);
    end
  end
endmodule

// File: tb/tb_fma_special_pipe.sv
// tb_fma_special_pipe: directed self-checking bench for fma_special_pipe (half precision).
module tb_fma_special_pipe;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0, in_ready, nonzero_mant = 1'b0, nan_prop = 1'b0;
  logic out_valid, out_ready = 1'b1, special, fflags_clr = 1'b0;
  logic [15:0] x = '0, y = '0, z = '0, sum = '0, result;
  logic [4:0] flags, fflags, expFf;
  int checks = 0, errors = 0;

  fma_special_pipe #(.EW(5), .MW(10)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .z(z), .sum(sum), .nonzero_mant(nonzero_mant), .nan_prop(nan_prop),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags),
    .special(special), .fflags_clr(fflags_clr), .fflags(fflags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] xi, yi, zi, si, input logic nzm, np);
    x = xi; y = yi; z = zi; sum = si; nonzero_mant = nzm; nan_prop = np;
  endtask

  task automatic runOp(input string tag, input logic [15:0] xi, yi, zi, si, input logic nzm, np,
                       input logic [15:0] eRes, input logic [4:0] eFl, input logic eSp);
    drive(xi, yi, zi, si, nzm, np);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_res"}, 32'(result), 32'(eRes));
    chk({tag, "_flags"}, 32'(flags), 32'(eFl));
    chk({tag, "_special"}, 32'(special), 32'(eSp));
    @(posedge clk); #1;
    expFf = expFf | eFl;
    chk({tag, "_fflags"}, 32'(fflags), 32'(expFf));
    chk({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  typedef struct { logic [15:0] s; logic nzm; logic [4:0] fl; } bOp;
  bOp burst[4];

  initial begin
    expFf = '0;
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_res", 32'(result), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_special", 32'(special), 32'd0);
    chk("rst_fflags", 32'(fflags), 32'd0);
    chk("rst_inready", 32'(in_ready), 32'd1);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    runOp("infsub", 16'h3C00, 16'h7C00, 16'hFC00, 16'h0000, 1'b0, 1'b0, 16'h7E00, 5'b10000, 1'b1);
    runOp("snanprop", 16'h7D00, 16'h3C00, 16'h3C00, 16'h0000, 1'b0, 1'b1, 16'h7F00, 5'b10000, 1'b1);
    runOp("snancan", 16'h7D00, 16'h3C00, 16'h3C00, 16'h0000, 1'b0, 1'b0, 16'h7E00, 5'b10000, 1'b1);
    runOp("qnan0inf", 16'h0000, 16'h7C00, 16'hFE01, 16'h0000, 1'b0, 1'b1, 16'hFE01, 5'b10000, 1'b1);
    runOp("qnanquiet", 16'h3C00, 16'h7E05, 16'h3C00, 16'h0000, 1'b0, 1'b1, 16'h7E05, 5'b00000, 1'b1);
    runOp("zeroinf", 16'h8000, 16'h7C00, 16'h3C00, 16'h0000, 1'b0, 1'b1, 16'h7E00, 5'b10000, 1'b1);
    runOp("prodinf", 16'h7C00, 16'hC000, 16'h3C00, 16'h0000, 1'b0, 1'b0, 16'hFC00, 5'b00000, 1'b1);
    runOp("zinf", 16'h3C00, 16'h3C00, 16'hFC00, 16'h0000, 1'b0, 1'b0, 16'hFC00, 5'b00000, 1'b1);
    runOp("negzero", 16'h8000, 16'h3C00, 16'h8000, 16'h1234, 1'b1, 1'b0, 16'h8000, 5'b00000, 1'b1);
    runOp("poszero", 16'h8000, 16'h8000, 16'h8000, 16'h1234, 1'b1, 1'b0, 16'h0000, 5'b00000, 1'b1);
    runOp("zeroz", 16'h0000, 16'h4000, 16'h4500, 16'h1234, 1'b1, 1'b0, 16'h4500, 5'b00000, 1'b1);

    fflags_clr = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    expFf = '0;
    chk("clr_fflags", 32'(fflags), 32'd0);
    runOp("ovf", 16'h7BFF, 16'h4000, 16'h0000, 16'h7C00, 1'b1, 1'b0, 16'h7C00, 5'b00101, 1'b0);
    runOp("uf", 16'h0400, 16'h0400, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'h0001, 5'b00011, 1'b0);
    runOp("exact", 16'h3C00, 16'h3C00, 16'h0000, 16'h3C00, 1'b0, 1'b0, 16'h3C00, 5'b00000, 1'b0);
    runOp("cancel", 16'h3C00, 16'h3C00, 16'hBC00, 16'h0000, 1'b0, 1'b0, 16'h0000, 5'b00000, 1'b0);

    // backpressure: A held while B waits
    drive(16'h3C00, 16'h3C00, 16'h0000, 16'h3C01, 1'b1, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp_inready", 32'(in_ready), 32'd0);
    drive(16'h3C00, 16'h4000, 16'h0000, 16'h4000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_res", 32'(result), 32'h3C01);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_flags", 32'(flags), 32'b00001);
      chk("bp_hold_fflags", 32'(fflags), 32'(expFf));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_inready_rel", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    expFf = expFf | 5'b00001;
    chk("bp_b_res", 32'(result), 32'h4000);
    chk("bp_fflags", 32'(fflags), 32'(expFf));

    // four back-to-back ops with in_valid held
    burst[0] = '{16'h4200, 1'b0, 5'b00000};
    burst[1] = '{16'h4400, 1'b1, 5'b00001};
    burst[2] = '{16'h4600, 1'b0, 5'b00000};
    burst[3] = '{16'h0010, 1'b1, 5'b00011};
    for (int i = 0; i < 4; i++) begin
      drive(16'h3C00, 16'h3C00, 16'h0000, burst[i].s, burst[i].nzm, 1'b0);
      @(posedge clk); #1;
      chk("b2b_res", 32'(result), 32'(burst[i].s));
      chk("b2b_flags", 32'(flags), 32'(burst[i].fl));
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_inready", 32'(in_ready), 32'd1);
      if (i > 0) expFf = expFf | burst[i-1].fl;
      chk("b2b_fflags", 32'(fflags), 32'(expFf));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    expFf = expFf | burst[3].fl;
    chk("b2b_fflags_end", 32'(fflags), 32'(expFf));
    chk("b2b_drained", 32'(out_valid), 32'd0);

    // clear coinciding with a delivery of NX
    chk("pre_clr_nonzero", 32'(fflags != 5'b00000), 32'd1);
    drive(16'h3C00, 16'h3C00, 16'h0000, 16'h3C01, 1'b1, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    fflags_clr = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    chk("clr_deliver", 32'(fflags), 32'b00001);

    // asynchronous reset mid-operation
    drive(16'h7BFF, 16'h4000, 16'h0000, 16'h7C00, 1'b1, 1'b0);
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    #2;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_fflags", 32'(fflags), 32'd0);
    chk("arst_res", 32'(result), 32'd0);
    chk("arst_flags", 32'(flags), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fma_special_pipe.md
Name: fma_special_pipe

Overview:
- Parametrised, pipelined special-case and exception-flag stage for the fused multiply-add datapath.
- Sits after the add/round stage. It resolves NaN, infinity, zero and overflow cases for result = x*y+z.
- Registers the result behind a valid/ready handshake and keeps a sticky accumulated flag register, as used by fflags.
- Generalises the half-precision combinational handler with the following additions:
  - any exponent/mantissa width
  - signalling-NaN detection
  - NaN-propagation mode
  - underflow flag
  - pipeline register and flag accumulation

Parameters:
EW, 5, exponent width in bits
MW, 10, stored mantissa width in bits (format width N = 1+EW+MW; default N=16)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set and datapath sum are valid
in_ready  output  1  stage can accept a new operand set
x  input  N  multiplicand
y  input  N  multiplier
z  input  N  addend
sum  input  N  rounded datapath result for x*y+z (RNE)
nonzero_mant  input  1  guard/round/sticky nonzero (rounding lost precision)
nan_prop  input  1  0: canonical NaN output; 1: propagate first NaN input, quieted
out_valid  output  1  result/flags valid
out_ready  input  1  downstream accepts result
result  output  N  final result
flags  output  5  {NV,DZ,OF,UF,NX} for this operation
special  output  1  result came from a special case, not from sum
fflags_clr  input  1  synchronous clear of accumulated flags
fflags  output  5  sticky OR of flags from all delivered results

Behaviour:
- Reset (reset_n low, asynchronous): out_valid=0, result=0, flags=0, special=0, fflags=0. Takes effect immediately mid-operation; any in-flight result is discarded.
- Handshake:
  - in_ready = ~out_valid | out_ready (combinational).
  - Accept when in_valid & in_ready; the output register loads on the next clk edge. Latency is 1 cycle.
  - out_valid holds high with stable result/flags/special until out_ready is sampled high.
  - Back-to-back accepts at full throughput are required when out_ready stays high.
- Field decode: exp all-ones with mant!=0 is NaN. A NaN with mant MSB=0 is sNaN. exp all-ones with mant=0 is inf. exp=0 with mant=0 is zero. Product sign ps = xs^ys.
- Canonical NaN: sign 0, exp all-ones, mant = 1 followed by zeros (0x7E00 for N=16).
- Propagated NaN (nan_prop=1): the first NaN in priority x, y, z, with mant MSB forced to 1 and sign kept.
- DZ is always 0.
- Priority (first match wins; special=1 for items 1-6):
  1. Any NaN input: result NaN (canonical or propagated). NV=1 if any sNaN, or if x*y is 0*inf; else NV=0.
  2. x*y is 0*inf or inf*0: canonical NaN, NV=1, regardless of z.
  3. x or y inf, z inf, zs != ps: canonical NaN, NV=1.
  4. x or y inf: inf with sign ps, no flags.
  5. z inf: result z, no flags.
  6. x or y zero:
     - z nonzero: result z.
     - z zero: result -0 if ps & zs, else +0.
     - No flags in either case.
  7. sum exp all-ones (overflow): inf with sum sign, OF=1, NX=1, special=0.
  8. Otherwise: result=sum, NX=nonzero_mant, UF = nonzero_mant & (sum exp==0), special=0.
- Accumulation:
  - fflags_next = (fflags_clr ? 0 : fflags) | (out_valid & out_ready ? flags : 0).
  - When clear and a delivery happen in the same cycle, the delivered flags survive the clear.
  - Flags of an undelivered result are never accumulated.
- Exact cancellation to zero with finite operands is produced by the datapath in sum and passes through item 8.

Test Plan:
- N=16, x=0x3C00, y=0x7C00, z=0xFC00 -> result 0x7E00, flags 10000, special=1.
- x=0x7D00 (sNaN), y=0x3C00, z=0x3C00, nan_prop=1 -> result 0x7F00, NV=1. Same stimulus with nan_prop=0 -> result 0x7E00.
- x=0x8000, y=0x3C00, z=0x8000 -> result 0x8000. Then x=0x8000, y=0x8000, z=0x8000 -> result 0x0000, no flags.
- x=0x7BFF, y=0x4000, z=0, sum=0x7C00, nonzero_mant=1 -> result 0x7C00, flags 00101. fflags becomes 00101 after delivery.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after the first accept, the output is unchanged, and fflags does not update until out_ready=1. Then 4 back-to-back operations complete in 4 cycles.
- Assert fflags_clr in the same cycle as a delivery with NX=1 -> fflags=00001. Pull reset_n low mid-stream -> out_valid and fflags go to 0 immediately, without waiting for clk.
